// File: rtl/tia_hmove_pkg.sv
// Shared constants and state encoding for the TIA horizontal-motion sequencer.
package tia_hmove_pkg;

    localparam int unsigned OBJ_P0 = 0;
    localparam int unsigned OBJ_P1 = 1;
    localparam int unsigned OBJ_M0 = 2;
    localparam int unsigned OBJ_M1 = 3;
    localparam int unsigned OBJ_BL = 4;

    localparam logic [3:0] HM_BIAS = 4'h8;
    localparam int unsigned HMOVE_STEPS = 16;

    typedef enum logic {
        StIdle,
        StRun
    } hm_state_e;

endpackage

// File: rtl/tia_hmove_comparator.sv
// One movable object's slice: HMxx register, run-enable flag and the registered
// extra motion-clock pulse.
module tia_hmove_comparator #(
    parameter logic [3:0] HM_BIAS = tia_hmove_pkg::HM_BIAS
) (
    input  logic       clk,
    input  logic       r,
    input  logic       hclk_en,
    input  logic       load,
    input  logic       step,
    input  logic [3:0] k,
    input  logic       hm_clr,
    input  logic       hm_wr,
    input  logic [3:0] wr_data,
    output logic       motck
);

    logic [3:0] hm_q, hm_d;
    logic       ena_q, ena_d;
    logic       motck_q, motck_d;
    logic [3:0] n_pulses;
    logic       eval;
    logic       ena_eff;
    logic       hit;

    assign n_pulses = hm_q ^ HM_BIAS;
    assign eval     = hclk_en & (load | step);
    // A load (start or restart) re-arms the object regardless of its old flag.
    assign ena_eff  = load | ena_q;
    assign hit      = ena_eff & (k < n_pulses);

    always_comb begin
        hm_d    = hm_q;
        ena_d   = ena_q;
        motck_d = 1'b0;
        if (hm_clr) begin
            hm_d = 4'h0;
        end else if (hm_wr) begin
            hm_d = wr_data;
        end
        if (eval) begin
            ena_d   = hit;
            motck_d = hit;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            hm_q    <= 4'h0;
            ena_q   <= 1'b0;
            motck_q <= 1'b0;
        end else begin
            hm_q    <= hm_d;
            ena_q   <= ena_d;
            motck_q <= motck_d;
        end
    end

    assign motck = motck_q;

endmodule

// File: rtl/tia_hmove_controller.sv
// HMOVE sequencer: pending strobe, 16-step run counter, SEC latch and the
// per-object comparator slices that emit extra motion-clock pulses.
module tia_hmove_controller #(
    parameter int unsigned NUM_OBJ = 5,
    parameter logic [3:0]  HM_BIAS = tia_hmove_pkg::HM_BIAS
) (
    input  logic               clk,
    input  logic               r,
    input  logic               hclk_en,
    input  logic               hmove,
    input  logic               hmclr,
    input  logic               hm_we,
    input  logic [2:0]         hm_sel,
    input  logic [3:0]         hm_d,
    input  logic               hblank,
    input  logic               lrhb,
    output logic [NUM_OBJ-1:0] motck_extra,
    output logic               active,
    output logic               sec
);

    import tia_hmove_pkg::*;

    hm_state_e  state_q, state_d;
    logic [3:0] k_q, k_d;
    logic       pending_q, pending_d;
    logic       sec_q, sec_d;
    logic       active_q, active_d;
    logic       start;
    logic       run_step;
    logic       running;
    logic [3:0] k_eval;

    assign running  = (state_q == StRun);
    assign start    = hclk_en & pending_q;
    assign run_step = hclk_en & running & ~pending_q;
    // A start evaluates step 0 in the same slot it loads the counter.
    assign k_eval   = pending_q ? 4'd0 : k_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pending_d = hmove | (pending_q & ~hclk_en);
        sec_d     = (hmove & hblank) | (sec_q & ~lrhb);
        active_d  = start | running;
        if (start) begin
            state_d = StRun;
            k_d     = 4'd1;
        end else if (run_step) begin
            if (k_q == 4'(HMOVE_STEPS - 1)) begin
                state_d = StIdle;
                k_d     = 4'd0;
            end else begin
                k_d = k_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q   <= StIdle;
            k_q       <= 4'd0;
            pending_q <= 1'b0;
            sec_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pending_q <= pending_d;
            sec_q     <= sec_d;
            active_q  <= active_d;
        end
    end

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        tia_hmove_comparator #(
            .HM_BIAS (HM_BIAS)
        ) u_cmp (
            .clk     (clk),
            .r       (r),
            .hclk_en (hclk_en),
            .load    (pending_q),
            .step    (running),
            .k       (k_eval),
            .hm_clr  (hmclr),
            .hm_wr   (hm_we & (hm_sel == 3'(i))),
            .wr_data (hm_d),
            .motck   (motck_extra[i])
        );
    end

    assign active = active_q;
    assign sec    = sec_q;

endmodule

// File: tb/tb_tia_hmove_controller.sv
// Directed self-checking bench for tia_hmove_controller.
module tb_tia_hmove_controller;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       hclk_en = 1'b0;
    logic       hmove = 1'b0;
    logic       hmclr = 1'b0;
    logic       hm_we = 1'b0;
    logic [2:0] hm_sel = 3'd0;
    logic [3:0] hm_d = 4'd0;
    logic       hblank = 1'b0;
    logic       lrhb = 1'b0;
    logic [4:0] motck_extra;
    logic       active;
    logic       sec;

    int nvec = 0;
    int nerr = 0;
    int phase = 0;
    int cyc_n = 0;
    int stray = 0;
    int gap_err = 0;
    int cnt[5];
    int last[5];

    always #5 clk = ~clk;

    tia_hmove_controller #(
        .NUM_OBJ (5),
        .HM_BIAS (4'h8)
    ) dut (
        .clk         (clk),
        .r           (r),
        .hclk_en     (hclk_en),
        .hmove       (hmove),
        .hmclr       (hmclr),
        .hm_we       (hm_we),
        .hm_sel      (hm_sel),
        .hm_d        (hm_d),
        .hblank      (hblank),
        .lrhb        (lrhb),
        .motck_extra (motck_extra),
        .active      (active),
        .sec         (sec)
    );

    // Pulse counters, per-object spacing and pulses outside active.
    always @(negedge clk) begin
        cyc_n++;
        if (!r) begin
            for (int i = 0; i < 5; i++) begin
                if (motck_extra[i]) begin
                    cnt[i]++;
                    if (last[i] != 0 && (cyc_n - last[i]) < 8 && (cyc_n - last[i]) != 4)
                        gap_err++;
                    last[i] = cyc_n;
                end
            end
            if (|motck_extra && !active) stray++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic hb, input logic lr, input logic clr,
                         input logic we, input logic [2:0] sel, input logic [3:0] d);
        @(negedge clk);
        hclk_en = (phase == 0);
        phase   = (phase == 3) ? 0 : phase + 1;
        hmove   = mv;
        hblank  = hb;
        lrhb    = lr;
        hmclr   = clr;
        hm_we   = we;
        hm_sel  = sel;
        hm_d    = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [3:0] d);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sel, d);
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 5; i++) cnt[i] = 0;
    endtask

    // hmove lands one cycle after an hclk_en, so step 0 is three cycles later.
    task automatic run_hmove();
        while (phase != 1) idle(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    endtask

    initial begin
        int snap;
        int low;
        int sec_seen;
        for (int i = 0; i < 5; i++) begin
            cnt[i]  = 0;
            last[i] = 0;
        end

        idle(3);
        check("rst_motck", 32'(motck_extra), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        check("rst_sec", 32'(sec), 32'h0);
        r = 1'b0;
        idle(2);

        // Reset mid-run
        wr(3'd0, 4'h7);
        run_hmove();
        idle(20);
        check("pre_rst_pulses", 32'(cnt[0] != 0), 32'h1);
        snap = cnt[0];
        r = 1'b1;
        #1;
        check("midrst_motck", 32'(motck_extra), 32'h0);
        check("midrst_active", 32'(active), 32'h0);
        check("midrst_sec", 32'(sec), 32'h0);
        idle(3);
        check("rst_no_pulse", 32'(cnt[0]), 32'(snap));
        r = 1'b0;
        idle(70);
        check("rst_pending_clr", 32'(cnt[0]), 32'(snap));
        clear_cnt();
        run_hmove();
        idle(70);
        check("rst_hm0_zero", 32'(cnt[0]), 32'd8);

        // Basic counts
        wr(3'd0, 4'h7);
        wr(3'd1, 4'h0);
        wr(3'd2, 4'h8);
        wr(3'd3, 4'hF);
        wr(3'd4, 4'h1);
        clear_cnt();
        run_hmove();
        idle(3);
        check("act_pre", 32'(active), 32'h0);
        idle(1);
        check("act_first", 32'(active), 32'h1);
        check("step0_pulses", 32'(motck_extra), 32'b11011);
        idle(60);
        check("act_last", 32'(active), 32'h1);
        idle(1);
        check("act_end", 32'(active), 32'h0);
        idle(4);
        check("cnt_p0", 32'(cnt[0]), 32'd15);
        check("cnt_p1", 32'(cnt[1]), 32'd8);
        check("cnt_m0", 32'(cnt[2]), 32'd0);
        check("cnt_m1", 32'(cnt[3]), 32'd7);
        check("cnt_bl", 32'(cnt[4]), 32'd9);

        // hmclr beats a same-cycle write; sel 5 is ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'h7);
        wr(3'd5, 4'h7);
        clear_cnt();
        run_hmove();
        idle(70);
        check("clr_p0", 32'(cnt[0]), 32'd8);
        check("clr_p1", 32'(cnt[1]), 32'd8);
        check("clr_m0", 32'(cnt[2]), 32'd8);
        check("clr_m1", 32'(cnt[3]), 32'd8);
        check("clr_bl", 32'(cnt[4]), 32'd8);

        // Mid-run write to BL after step 3
        wr(3'd4, 4'h7);
        clear_cnt();
        run_hmove();
        idle(15);
        wr(3'd4, 4'h8);
        idle(60);
        check("midrun_bl", 32'(cnt[4]), 32'd4);

        // Restart at step 10
        wr(3'd0, 4'h7);
        clear_cnt();
        run_hmove();
        idle(3);
        low = 0;
        for (int j = 0; j < 105; j++) begin
            drive((j == 39), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
            if (!active) low++;
        end
        check("restart_act_cont", 32'(low), 32'd0);
        idle(1);
        check("restart_end", 32'(active), 32'h0);
        idle(4);
        check("restart_p0", 32'(cnt[0]), 32'd26);

        // SEC latch
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        check("sec_pre", 32'(sec), 32'h0);
        idle(1);
        check("sec_set", 32'(sec), 32'h1);
        idle(5);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        idle(1);
        check("sec_clr", 32'(sec), 32'h0);
        idle(70);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        clear_cnt();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        sec_seen = 0;
        for (int j = 0; j < 70; j++) begin
            idle(1);
            if (sec) sec_seen++;
        end
        check("sec_nohb", 32'(sec_seen), 32'd0);
        check("sec_nohb_pulses", 32'(cnt[1]), 32'd8);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        idle(1);
        check("sec_set_wins", 32'(sec), 32'h1);
        idle(70);

        check("no_stray_pulse", 32'(stray), 32'd0);
        check("pulse_spacing", 32'(gap_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
